// File: rtl/sram_pkg.sv
// sram_pkg: shared encodings, macro geometry and aspect-ratio helpers for the banked SRAM unit.
package sram_pkg;

    localparam int MACRO_W = 32;
    localparam int MACRO_D = 512;

    typedef enum logic [2:0] {
        CONF_W1  = 3'd0,
        CONF_W2  = 3'd1,
        CONF_W4  = 3'd2,
        CONF_W8  = 3'd3,
        CONF_W16 = 3'd4,
        CONF_W32 = 3'd5,
        CONF_R6  = 3'd6,
        CONF_R7  = 3'd7
    } conf_e;

    // Encodings above CONF_W32 behave as full-word access.
    function automatic logic [2:0] conf_log2(input logic [2:0] conf);
        return (conf > 3'(CONF_W32)) ? 3'(CONF_W32) : conf;
    endfunction

    function automatic logic [5:0] width_from_conf(input logic [2:0] conf);
        return 6'd1 << conf_log2(conf);
    endfunction

    function automatic logic [MACRO_W-1:0] lane_mask(input logic [2:0] conf);
        return (conf_log2(conf) == 3'(CONF_W32)) ? '1 : ((32'd1 << width_from_conf(conf)) - 32'd1);
    endfunction

    function automatic logic [4:0] lane_offset(input logic [4:0] bit_addr, input logic [2:0] conf);
        logic [4:0] keep;
        keep = 5'h1f << conf_log2(conf);
        return bit_addr & keep;
    endfunction

endpackage

// File: rtl/sram_width_adapter.sv
// sram_width_adapter: maps narrow lanes onto 32-bit macro words (write mask/shift) and back (read extract).
module sram_width_adapter
    import sram_pkg::*;
(
    input  logic [2:0]         wr_conf_i,
    input  logic [4:0]         wr_bit_i,
    input  logic [MACRO_W-1:0] wr_data_i,
    output logic [MACRO_W-1:0] wr_word_o,
    output logic [MACRO_W-1:0] wr_mask_o,
    input  logic [2:0]         rd_conf_i,
    input  logic [4:0]         rd_bit_i,
    input  logic [MACRO_W-1:0] rd_word_i,
    output logic [MACRO_W-1:0] rd_lane_o
);

    logic [4:0] wr_off;

    assign wr_off    = lane_offset(wr_bit_i, wr_conf_i);
    assign wr_mask_o = lane_mask(wr_conf_i) << wr_off;
    assign wr_word_o = (wr_data_i & lane_mask(wr_conf_i)) << wr_off;
    assign rd_lane_o = (rd_word_i >> lane_offset(rd_bit_i, rd_conf_i)) & lane_mask(rd_conf_i);

endmodule

// File: rtl/sram_unit_dp_mb.sv
// sram_unit_dp_mb: multi-bank 1rw1r SRAM with configurable aspect ratio, one read and one write per cycle.
// Pipeline: command register (E0) -> macro access (E1) -> optional output register.
module sram_unit_dp_mb
    import sram_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int WORDS     = MACRO_D,
    parameter int ADDR_W    = 5 + $clog2(WORDS) + $clog2(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        conf,
    input  logic              out_reg,
    output logic [31:0]       rd_data,
    output logic              rd_valid
);

    localparam int RW = $clog2(WORDS);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef logic [BW-1:0] bank_t;
    typedef logic [RW-1:0] row_t;

    function automatic bank_t bank_of(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] t;
        t = a >> (5 + RW);
        return t[BW-1:0];
    endfunction

    function automatic row_t row_of(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] t;
        t = a >> 5;
        return t[RW-1:0];
    endfunction

    logic               wr_v_q, rd_v_q, rd_oreg_q;
    bank_t              wr_bank_q, rd_bank_q;
    row_t               wr_row_q, rd_row_q;
    logic [MACRO_W-1:0] wr_word_d, wr_mask_d, wr_word_q, wr_mask_q;
    logic [4:0]         rd_bit_q;
    logic [2:0]         rd_conf_q;

    logic               rd_v2_q, oreg2_q;
    bank_t              bank2_q;
    logic [4:0]         bit2_q;
    logic [2:0]         conf2_q;

    logic               rd_v3_q;
    logic [MACRO_W-1:0] data3_q, hold_q, lane;

    logic [NUM_BANKS-1:0]              csb0, web0, csb1;
    logic [NUM_BANKS-1:0][MACRO_W-1:0] dout;

    sram_width_adapter u_adapter (
        .wr_conf_i (conf),
        .wr_bit_i  (wr_addr[4:0]),
        .wr_data_i (wr_data),
        .wr_word_o (wr_word_d),
        .wr_mask_o (wr_mask_d),
        .rd_conf_i (conf2_q),
        .rd_bit_i  (bit2_q),
        .rd_word_i (dout[bank2_q]),
        .rd_lane_o (lane)
    );

    // Selects are gated by rst so a write caught in the command stage never reaches a macro.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [MACRO_W-1:0] mem [WORDS];
        logic [MACRO_W-1:0] merged, dout_q;
        assign csb0[b] = !(wr_v_q && !rst && wr_bank_q == bank_t'(b));
        assign web0[b] = csb0[b];
        assign csb1[b] = !(rd_v_q && !rst && rd_bank_q == bank_t'(b));
        assign merged  = (mem[wr_row_q] & ~wr_mask_q) | (wr_word_q & wr_mask_q);
        assign dout[b] = dout_q;
        always_ff @(posedge clk) begin
            if (!csb0[b] && !web0[b]) mem[wr_row_q] <= merged;
            if (!csb1[b]) dout_q <= (!csb0[b] && !web0[b] && wr_row_q == rd_row_q) ? merged : mem[rd_row_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_v_q  <= 1'b0;
            rd_v_q  <= 1'b0;
            rd_v2_q <= 1'b0;
            rd_v3_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            wr_v_q  <= wr_en;
            rd_v_q  <= rd_en;
            rd_v2_q <= rd_v_q;
            rd_v3_q <= rd_v2_q && oreg2_q;
            if (rd_valid) hold_q <= rd_data;
        end
        wr_bank_q <= bank_of(wr_addr);
        wr_row_q  <= row_of(wr_addr);
        wr_word_q <= wr_word_d;
        wr_mask_q <= wr_mask_d;
        rd_bank_q <= bank_of(rd_addr);
        rd_row_q  <= row_of(rd_addr);
        rd_bit_q  <= rd_addr[4:0];
        rd_conf_q <= conf;
        rd_oreg_q <= out_reg;
        bank2_q   <= rd_bank_q;
        bit2_q    <= rd_bit_q;
        conf2_q   <= rd_conf_q;
        oreg2_q   <= rd_oreg_q;
        data3_q   <= lane;
    end

    assign rd_valid = (rd_v2_q && !oreg2_q) || rd_v3_q;
    assign rd_data  = rd_v3_q ? data3_q : (rd_v2_q && !oreg2_q) ? lane : hold_q;

endmodule
